stepper_pulse_gen: RTL and testbench
====================================

# stepper_pulse_gen

Parametrised multi-channel step/direction pulse generator for the motor PMOD path. It replaces the fixed two-channel, one-toggle-per-clock motor controller. Each channel gets its own step count and a shared programmable pulse rate. Channels run concurrently, abort is supported, and completion is reported through a level handshake with the host-side command word.

## Interface
Parameters:
- NUM_CH, 2, number of motor channels
- CNT_W, 30, step-count width per channel
- DIV_W, 16, half-period divider width

Ports:
- FSM_Clk  in  1  block clock; all logic on its rising edge
- FSM_Rst_n  in  1  asynchronous, active-low reset
- cmd_start  in  1  level command; a high level in IDLE starts a move
- cmd_abort  in  1  level; stops an active move
- cmd_dir  in  NUM_CH  per-channel direction, latched at start
- cmd_steps  in  NUM_CH*CNT_W  per-channel step counts; channel i uses bits [i*CNT_W +: CNT_W]; latched at start
- cmd_half_period  in  DIV_W  FSM_Clk cycles per step half-period; latched at start; 0 is treated as 1
- step_en  out  NUM_CH  step pulse outputs (PMOD EN pins)
- step_dir  out  NUM_CH  direction outputs (PMOD DIR pins)
- busy  out  1  high in RUN
- done  out  1  high in DONE
- aborted  out  1  high in DONE when the move ended by abort
- State  out  2  FSM state: 0 IDLE, 1 RUN, 2 DONE

## Operation
- Reset (asynchronous, FSM_Rst_n low):
  - State=IDLE.
  - step_en, step_dir, busy, done and aborted are all 0.
  - Internal counters and latches are cleared.
- IDLE:
  - With cmd_start=1 on an edge, latch per-channel remaining=cmd_steps, dir=cmd_dir and H=max(cmd_half_period,1), then clear the divider.
  - If every remaining count is 0, go to DONE with aborted=0. Otherwise go to RUN.
  - cmd_abort is ignored in IDLE.
- RUN:
  - step_dir = latched dir throughout. busy=1.
  - The divider counts 0..H-1. At H-1 it wraps to 0 and produces a tick.
  - On each tick, every channel with remaining≠0 toggles step_en.
  - On a high→low toggle, that channel's remaining decrements by 1.
  - A channel with remaining=0 holds step_en=0.
  - When the tick's falling toggles leave every remaining at 0, State→DONE on the same edge.
  - cmd_abort=1 on any RUN edge has priority over the tick:
    - step_en→0 on all channels and State→DONE with aborted=1.
    - remaining counts are frozen.
- DONE:
  - done=1, busy=0, step_en=0, step_dir=0. aborted holds its value.
  - When cmd_start=0 on an edge, go to IDLE and clear aborted and done.
  - cmd_start held high keeps the block in DONE, so a level held high never retriggers.
- Latched values are immune to command changes during RUN or DONE.
- Counters do not wrap: remaining saturates at 0, and the divider resets on each state entry.

## Timing
- Start latency: cmd_start sampled high at edge N puts State=RUN after edge N, with step_dir valid from that same edge.
- With RUN entered at edge R:
  - Channel i's step_en rises after edge R+H.
  - It falls after edge R+2H.
  - Its period is 2H cycles at 50% duty.
  - It produces exactly cmd_steps[i] high pulses.
- Completion: the last falling edge of the longest channel and State=DONE/done=1 occur on the same edge, R+2H·max(steps).
- Shorter channels go idle low after their own last falling edge; the other channels are unaffected.
- Abort: sampled at edge A, all outputs reach their DONE values after edge A. A partially completed high pulse is cut short.
- Zero-step start: DONE is reached one edge after start, and step_en never toggles.
- Reset asserted mid-RUN: step_en and the other outputs go to 0 asynchronously, with no wait for a clock edge.
- Release: the first edge with FSM_Rst_n=1 performs normal IDLE evaluation.
- H=1 gives the maximum rate, FSM_Clk/2, which matches the previous generation's behaviour.

## Test plan
- Configuration NUM_CH=2, H=4, steps={3,1}, dir={1,0}, start held high:
  - ch0 produces 3 pulses of period 8 and ch1 produces 1 pulse; both rise at R+4.
  - step_dir=2'b01 during RUN.
  - done at R+24, then returns to IDLE 1 edge after start drops.
- Abort: steps={100,100}, H=2, cmd_abort at R+7 → step_en=0 and aborted=1 after that edge; done=1; a subsequent start low then high begins a fresh move.
- Zero steps: steps={0,0} → DONE one edge after start, no step_en activity, aborted=0.
- Half-period 0: cmd_half_period=0, steps={2,0} → ch0 toggles every cycle (period 2), done at R+4.
- Reset mid-RUN: FSM_Rst_n low at R+5 → all outputs 0 immediately; after release with start held high, a new move latches the current command.
- Command change during RUN: alter cmd_steps, cmd_dir and cmd_half_period at R+3 → pulse count, direction and period remain those latched at start.

Source files
------------

// File: rtl/stepper_pulse_gen.sv
// Multi-channel step/direction pulse generator with a shared half-period divider,
// per-channel step counts, abort, and a level start/done handshake.
//
// state | meaning
// IDLE  | waiting for cmd_start; command latched on the start edge
// RUN   | divider ticking, channels toggling step_en until all counts reach 0
// DONE  | move finished or aborted; held until cmd_start drops
module stepper_pulse_gen #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 30,
  parameter int DIV_W  = 16
) (
  input  logic                    FSM_Clk,
  input  logic                    FSM_Rst_n,
  input  logic                    cmd_start,
  input  logic                    cmd_abort,
  input  logic [NUM_CH-1:0]       cmd_dir,
  input  logic [NUM_CH*CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0]        cmd_half_period,
  output logic [NUM_CH-1:0]       step_en,
  output logic [NUM_CH-1:0]       step_dir,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic [1:0]              State
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   rem_q [NUM_CH];
  logic [CNT_W-1:0]   rem_d [NUM_CH];
  logic [NUM_CH-1:0]  dir_q, dir_d;
  logic [NUM_CH-1:0]  en_q, en_d;
  logic [DIV_W-1:0]   half_q, half_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               aborted_q, aborted_d;
  logic               tick;
  logic               any_left;

  always_ff @(posedge FSM_Clk or negedge FSM_Rst_n) begin
    if (!FSM_Rst_n) begin
      state_q   <= S_IDLE;
      rem_q     <= '{default: '0};
      dir_q     <= '0;
      en_q      <= '0;
      half_q    <= '0;
      div_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      dir_q     <= dir_d;
      en_q      <= en_d;
      half_q    <= half_d;
      div_q     <= div_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    dir_d     = dir_q;
    en_d      = en_q;
    half_d    = half_q;
    div_d     = div_q;
    aborted_d = aborted_q;
    any_left  = 1'b0;
    tick      = (div_q == half_q - DIV_W'(1));

    unique case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          for (int i = 0; i < NUM_CH; i++) begin
            rem_d[i] = cmd_steps[i*CNT_W +: CNT_W];
          end
          dir_d     = cmd_dir;
          half_d    = (cmd_half_period == '0) ? DIV_W'(1) : cmd_half_period;
          div_d     = '0;
          en_d      = '0;
          aborted_d = 1'b0;
          state_d   = (cmd_steps == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // abort outranks a coincident tick; remaining counts stay frozen
        if (cmd_abort) begin
          en_d      = '0;
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (tick) begin
          div_d = '0;
          for (int i = 0; i < NUM_CH; i++) begin
            if (rem_q[i] != '0) begin
              en_d[i] = ~en_q[i];
              if (en_q[i]) begin
                rem_d[i] = rem_q[i] - CNT_W'(1);
              end
            end
            any_left = any_left | (rem_d[i] != '0);
          end
          if (!any_left) begin
            state_d = S_DONE;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        en_d = '0;
        if (!cmd_start) begin
          aborted_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    State    = state_q;
    busy     = (state_q == S_RUN);
    done     = (state_q == S_DONE);
    aborted  = aborted_q;
    step_en  = (state_q == S_RUN) ? en_q  : '0;
    step_dir = (state_q == S_RUN) ? dir_q : '0;
  end

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Directed and randomized moves checked cycle by cycle against an arithmetic
// waveform model of each channel's step train.
module tb_stepper_pulse_gen;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 30;
  localparam int DIV_W  = 16;

  logic                    FSM_Clk = 1'b0;
  logic                    FSM_Rst_n;
  logic                    cmd_start;
  logic                    cmd_abort;
  logic [NUM_CH-1:0]       cmd_dir;
  logic [NUM_CH*CNT_W-1:0] cmd_steps;
  logic [DIV_W-1:0]        cmd_half_period;
  logic [NUM_CH-1:0]       step_en;
  logic [NUM_CH-1:0]       step_dir;
  logic                    busy;
  logic                    done;
  logic                    aborted;
  logic [1:0]              State;

  int checks = 0;
  int errors = 0;

  stepper_pulse_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .FSM_Clk         (FSM_Clk),
    .FSM_Rst_n       (FSM_Rst_n),
    .cmd_start       (cmd_start),
    .cmd_abort       (cmd_abort),
    .cmd_dir         (cmd_dir),
    .cmd_steps       (cmd_steps),
    .cmd_half_period (cmd_half_period),
    .step_en         (step_en),
    .step_dir        (step_dir),
    .busy            (busy),
    .done            (done),
    .aborted         (aborted),
    .State           (State)
  );

  always #5 FSM_Clk = ~FSM_Clk;

  task automatic step();
    @(posedge FSM_Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // k edges after entering RUN: high during odd half-periods, for s full periods
  function automatic logic exp_en(input int k, input int h, input int s);
    return (k < 2 * h * s) && (((k / h) % 2) == 1);
  endfunction

  task automatic do_move(input int s0, input int s1, input logic [1:0] d, input int hp,
                         input int abort_k, input int change_k);
    int  h, mx, total, end_k;
    bit  ab, ended;
    logic [1:0] en_exp;
    h     = (hp == 0) ? 1 : hp;
    mx    = (s0 > s1) ? s0 : s1;
    total = 2 * h * mx;
    ab    = (abort_k > 0) && (abort_k <= total);
    end_k = ab ? abort_k : total;
    cmd_steps       = {CNT_W'(s1), CNT_W'(s0)};
    cmd_dir         = d;
    cmd_half_period = DIV_W'(hp);
    cmd_abort       = 1'b0;
    cmd_start       = 1'b1;
    for (int k = 0; k <= end_k + 2; k++) begin
      step();
      ended  = (k >= end_k);
      en_exp = ended ? 2'b00 : {exp_en(k, h, s1), exp_en(k, h, s0)};
      chk("state", 32'(State), ended ? 32'd2 : 32'd1);
      chk("step_en", 32'(step_en), 32'(en_exp));
      chk("step_dir", 32'(step_dir), ended ? 32'd0 : 32'(d));
      chk("flags", 32'({busy, done, aborted}), ended ? 32'({2'b01, ab}) : 32'd4);
      if (k + 1 == abort_k) cmd_abort = 1'b1;
      if (k + 1 == change_k) begin
        cmd_steps       = {CNT_W'($urandom_range(0, 50)), CNT_W'($urandom_range(0, 50))};
        cmd_dir         = 2'($urandom);
        cmd_half_period = DIV_W'($urandom_range(0, 9));
      end
    end
    cmd_abort = 1'b0;
    cmd_start = 1'b0;
    step();
    chk("idle_state", 32'(State), 32'd0);
    chk("idle_flags", 32'({busy, done, aborted, step_en, step_dir}), 32'd0);
  endtask

  initial begin
    FSM_Rst_n       = 1'b0;
    cmd_start       = 1'b0;
    cmd_abort       = 1'b0;
    cmd_dir         = '0;
    cmd_steps       = '0;
    cmd_half_period = '0;
    #7;
    chk("reset_state", 32'(State), 32'd0);
    chk("reset_outs", 32'({busy, done, aborted, step_en, step_dir}), 32'd0);
    #5 FSM_Rst_n = 1'b1;
    step();
    chk("idle_hold", 32'(State), 32'd0);

    do_move(3, 1, 2'b01, 4, 0, 0);
    do_move(100, 100, 2'b11, 2, 7, 0);
    do_move(0, 0, 2'b11, 3, 0, 0);
    do_move(2, 0, 2'b01, 0, 0, 0);
    do_move(4, 2, 2'b10, 3, 0, 3);
    do_move(1, 3, 2'b11, 1, 0, 0);
    do_move(2, 2, 2'b01, 2, 8, 0);

    // reset in the middle of a move, then restart with start still held high
    cmd_steps       = {CNT_W'(5), CNT_W'(5)};
    cmd_dir         = 2'b11;
    cmd_half_period = DIV_W'(2);
    cmd_start       = 1'b1;
    step();
    chk("rst_run", 32'(State), 32'd1);
    repeat (5) step();
    chk("rst_pre_dir", 32'(step_dir), 32'd3);
    #2 FSM_Rst_n = 1'b0;
    #1;
    chk("rst_async_state", 32'(State), 32'd0);
    chk("rst_async_outs", 32'({busy, done, aborted, step_en, step_dir}), 32'd0);
    #3 FSM_Rst_n = 1'b1;
    do_move(2, 1, 2'b10, 1, 0, 0);

    for (int n = 0; n < 14; n++) begin
      do_move(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 2'($urandom),
              int'($urandom_range(0, 4)),
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : 0,
              int'($urandom_range(1, 10)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
